smi_mem_lib_read_burst_test_sink_64: RTL and testbench

Read-side counterpart of the memory library write burst test source. It accepts a test command, issues one read burst request to the read burst controller, and checks each returned 64-bit word against a counting sequence (init, init+incr, ...). It reports pass/fail plus mismatch diagnostics. It is used with the write test source to run write-then-readback memory tests.

---
 rtl/smi_mem_lib_read_burst_test_sink_64.sv | 155 +++++++++++++++
 tb/tb_smi_mem_lib_read_burst_test_sink_64.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_mem_lib_read_burst_test_sink_64.sv
// Read-burst test sink: issues one read burst per test command and checks the
// returned 64-bit words against a counting sequence, reporting pass/fail and diagnostics.
module smi_mem_lib_read_burst_test_sink_64 #(
    parameter int unsigned ERR_CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     arst_n,

    input  logic                     testParamsValid,
    input  logic [63:0]              testParamBurstAddr,
    input  logic [31:0]              testParamBurstLen,
    input  logic [7:0]               testParamBurstOpts,
    input  logic [63:0]              testParamDataInit,
    input  logic [63:0]              testParamDataIncr,
    output logic                     testParamsStop,

    output logic                     testDoneValid,
    output logic                     testDoneStatusOk,
    output logic [ERR_CNT_WIDTH-1:0] testDoneErrCount,
    output logic [31:0]              testDoneFirstErrIdx,
    input  logic                     testDoneStop,

    output logic                     readParamsValid,
    output logic [63:0]              readParamBurstAddr,
    output logic [31:0]              readParamBurstLen,
    output logic [7:0]               readParamBurstOpts,
    input  logic                     readParamsStop,

    input  logic                     readDataValid,
    input  logic [63:0]              readDataValue,
    output logic                     readDataStop,

    input  logic                     readDoneValid,
    input  logic                     readDoneStatusOk,
    output logic                     readDoneStop
);

    typedef enum logic [1:0] {
        IDLE,
        SET_PARAMS,
        CHECK_DATA,
        GET_STATUS
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [63:0]              addr;
    logic [31:0]              len;
    logic [7:0]               opts;
    logic [63:0]              expected;
    logic [63:0]              incr;
    logic [31:0]              counter;

    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic [31:0]              first_err_idx;
    logic                     err_seen;

    logic                     data_take;
    logic                     mismatch;

    // readDataStop is low only in CHECK_DATA, so valid alone marks a transfer there.
    assign data_take = (state == CHECK_DATA) && readDataValid;
    assign mismatch  = data_take && (readDataValue != expected);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            addr     <= testParamBurstAddr;
            len      <= testParamBurstLen;
            opts     <= testParamBurstOpts;
            expected <= testParamDataInit;
            incr     <= testParamDataIncr;
            counter  <= testParamBurstLen;
        end else if (data_take) begin
            expected <= expected + incr;
            counter  <= counter - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_count     <= '0;
            first_err_idx <= '1;
            err_seen      <= 1'b0;
        end else if (state == IDLE) begin
            err_count     <= '0;
            first_err_idx <= '1;
            err_seen      <= 1'b0;
        end else if (mismatch) begin
            if (err_count != '1) begin
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
            // Counter counts down from len, so len - counter is the word index.
            if (!err_seen) begin
                first_err_idx <= len - counter;
                err_seen      <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        testParamsStop  = 1'b1;
        readParamsValid = 1'b0;
        readDataStop    = 1'b1;
        testDoneValid   = 1'b0;
        readDoneStop    = 1'b1;

        case (state)
            IDLE: begin
                testParamsStop = !arst_n;
                if (testParamsValid) begin
                    state_nxt = SET_PARAMS;
                end
            end
            SET_PARAMS: begin
                readParamsValid = 1'b1;
                if (!readParamsStop) begin
                    state_nxt = (len != 32'd0) ? CHECK_DATA : GET_STATUS;
                end
            end
            CHECK_DATA: begin
                readDataStop = 1'b0;
                if (readDataValid && (counter == 32'd1)) begin
                    state_nxt = GET_STATUS;
                end
            end
            GET_STATUS: begin
                testDoneValid = readDoneValid;
                readDoneStop  = testDoneStop;
                if (readDoneValid && !testDoneStop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign readParamBurstAddr  = addr;
    assign readParamBurstLen   = len;
    assign readParamBurstOpts  = opts;

    assign testDoneStatusOk    = readDoneStatusOk && (err_count == '0);
    assign testDoneErrCount    = err_count;
    assign testDoneFirstErrIdx = first_err_idx;

endmodule

// File: tb/tb_smi_mem_lib_read_burst_test_sink_64.sv
// Self-checking bench for smi_mem_lib_read_burst_test_sink_64: acts as the read
// burst controller/memory and scoreboards requests and test completions.
module tb_smi_mem_lib_read_burst_test_sink_64;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        testParamsValid;
    logic [63:0] testParamBurstAddr;
    logic [31:0] testParamBurstLen;
    logic [7:0]  testParamBurstOpts;
    logic [63:0] testParamDataInit;
    logic [63:0] testParamDataIncr;
    logic        testParamsStop;
    logic        testDoneValid;
    logic        testDoneStatusOk;
    logic [31:0] testDoneErrCount;
    logic [31:0] testDoneFirstErrIdx;
    logic        testDoneStop;
    logic        readParamsValid;
    logic [63:0] readParamBurstAddr;
    logic [31:0] readParamBurstLen;
    logic [7:0]  readParamBurstOpts;
    logic        readParamsStop;
    logic        readDataValid;
    logic [63:0] readDataValue;
    logic        readDataStop;
    logic        readDoneValid;
    logic        readDoneStatusOk;
    logic        readDoneStop;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        logic [7:0]  opts;
    } req_t;

    typedef struct {
        logic        ok;
        logic [31:0] err_count;
        logic [31:0] first_idx;
    } res_t;

    req_t        req_q[$];
    res_t        res_q[$];
    logic [63:0] data_q[$];

    always #5 clk = ~clk;

    smi_mem_lib_read_burst_test_sink_64 #(.ERR_CNT_WIDTH(32)) dut (
        .clk                 (clk),
        .arst_n              (arst_n),
        .testParamsValid     (testParamsValid),
        .testParamBurstAddr  (testParamBurstAddr),
        .testParamBurstLen   (testParamBurstLen),
        .testParamBurstOpts  (testParamBurstOpts),
        .testParamDataInit   (testParamDataInit),
        .testParamDataIncr   (testParamDataIncr),
        .testParamsStop      (testParamsStop),
        .testDoneValid       (testDoneValid),
        .testDoneStatusOk    (testDoneStatusOk),
        .testDoneErrCount    (testDoneErrCount),
        .testDoneFirstErrIdx (testDoneFirstErrIdx),
        .testDoneStop        (testDoneStop),
        .readParamsValid     (readParamsValid),
        .readParamBurstAddr  (readParamBurstAddr),
        .readParamBurstLen   (readParamBurstLen),
        .readParamBurstOpts  (readParamBurstOpts),
        .readParamsStop      (readParamsStop),
        .readDataValid       (readDataValid),
        .readDataValue       (readDataValue),
        .readDataStop        (readDataStop),
        .readDoneValid       (readDoneValid),
        .readDoneStatusOk    (readDoneStatusOk),
        .readDoneStop        (readDoneStop)
    );

    task automatic send_cmd(input logic [63:0] a, input logic [31:0] l, input logic [7:0] o,
                            input logic [63:0] init, input logic [63:0] inc);
        int n = 0;
        @(negedge clk);
        while (testParamsStop && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (testParamsStop !== 1'b0) begin
            errors++;
            $display("FAIL cmd_ready: testParamsStop=%b required 0", testParamsStop);
        end
        testParamsValid    = 1'b1;
        testParamBurstAddr = a;
        testParamBurstLen  = l;
        testParamBurstOpts = o;
        testParamDataInit  = init;
        testParamDataIncr  = inc;
        req_q.push_back('{addr: a, len: l, opts: o});
        @(negedge clk);
        testParamsValid    = 1'b0;
        testParamBurstAddr = {$urandom, $urandom};
        testParamBurstLen  = $urandom;
        testParamDataInit  = {$urandom, $urandom};
        checks++;
        if (readParamsValid !== 1'b1) begin
            errors++;
            $display("FAIL req_latency: readParamsValid=%b required 1", readParamsValid);
        end
    endtask

    task automatic accept_req(input bit rand_stop);
        int   n    = 0;
        bit   done = 0;
        req_t e;
        while (!done && n < 100) begin
            readParamsStop = rand_stop ? ($urandom_range(0, 1) == 1) : 1'b0;
            #1;
            checks++;
            if (readParamsValid !== 1'b1) begin
                errors++;
                $display("FAIL req_valid_hold: readParamsValid=%b required 1", readParamsValid);
            end
            if (readParamsValid && !readParamsStop) begin
                e = req_q.pop_front();
                checks++;
                if ({readParamBurstAddr, readParamBurstLen, readParamBurstOpts} !== {e.addr, e.len, e.opts}) begin
                    errors++;
                    $display("FAIL req_fields: addr=%h len=%0d opts=%h required addr=%h len=%0d opts=%h",
                             readParamBurstAddr, readParamBurstLen, readParamBurstOpts, e.addr, e.len, e.opts);
                end
                done = 1;
            end
            @(negedge clk);
            n++;
        end
        readParamsStop = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: no request handshake in %0d cycles, required one", n);
        end
    endtask

    task automatic feed_words(input bit rand_gap);
        int n    = 0;
        int i    = 0;
        int size = data_q.size();
        while (i < size && n < 1000) begin
            if (rand_gap && $urandom_range(0, 2) == 0) begin
                readDataValid = 1'b0;
                readDataValue = {$urandom, $urandom};
            end else begin
                readDataValid = 1'b1;
                readDataValue = data_q[i];
            end
            #1;
            if (readDataValid && !readDataStop) i++;
            @(negedge clk);
            n++;
        end
        readDataValid = 1'b0;
        checks++;
        if (i != size) begin
            errors++;
            $display("FAIL data_timeout: accepted %0d words required %0d", i, size);
        end
        checks++;
        if (readDataStop !== 1'b1) begin
            errors++;
            $display("FAIL data_stop_after_last: readDataStop=%b required 1", readDataStop);
        end
    endtask

    task automatic finish_done(input logic ok, input int hold);
        res_t e;
        checks++;
        if (testDoneValid !== 1'b0) begin
            errors++;
            $display("FAIL done_idle_valid: testDoneValid=%b required 0", testDoneValid);
        end
        readDoneValid    = 1'b1;
        readDoneStatusOk = ok;
        testDoneStop     = 1'b1;
        for (int c = 0; c < hold; c++) begin
            #1;
            checks++;
            if ({testDoneValid, readDoneStop} !== 2'b11) begin
                errors++;
                $display("FAIL done_hold: valid=%b readDoneStop=%b required 1 1", testDoneValid, readDoneStop);
            end
            @(negedge clk);
        end
        testDoneStop = 1'b0;
        #1;
        e = res_q.pop_front();
        checks++;
        if ({testDoneValid, readDoneStop} !== 2'b10) begin
            errors++;
            $display("FAIL done_handshake: valid=%b readDoneStop=%b required 1 0", testDoneValid, readDoneStop);
        end
        checks++;
        if ({testDoneStatusOk, testDoneErrCount, testDoneFirstErrIdx} !== {e.ok, e.err_count, e.first_idx}) begin
            errors++;
            $display("FAIL done_result: ok=%b errs=%0d first=%h required ok=%b errs=%0d first=%h",
                     testDoneStatusOk, testDoneErrCount, testDoneFirstErrIdx, e.ok, e.err_count, e.first_idx);
        end
        @(negedge clk);
        readDoneValid = 1'b0;
        #1;
        checks++;
        if (testParamsStop !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: testParamsStop=%b required 0", testParamsStop);
        end
    endtask

    task automatic run_test(input logic [63:0] a, input logic [31:0] l, input logic [7:0] o,
                            input logic [63:0] init, input logic [63:0] inc,
                            input int bad0, input int bad1, input logic ok,
                            input bit rnd, input int hold);
        logic [63:0] v     = init;
        int          nerr  = 0;
        logic [31:0] first = '1;
        data_q.delete();
        for (int i = 0; i < int'(l); i++) begin
            if (i == bad0 || i == bad1) begin
                data_q.push_back(v ^ 64'h0000_0100_0000_005a);
                if (nerr == 0) first = i;
                nerr++;
            end else begin
                data_q.push_back(v);
            end
            v = v + inc;
        end
        res_q.push_back('{ok: ok && (nerr == 0), err_count: nerr, first_idx: first});
        send_cmd(a, l, o, init, inc);
        accept_req(rnd);
        if (l == 0) begin
            for (int c = 0; c < 3; c++) begin
                readDataValid = 1'b1;
                readDataValue = init;
                #1;
                checks++;
                if (readDataStop !== 1'b1) begin
                    errors++;
                    $display("FAIL len0_no_data: readDataStop=%b required 1", readDataStop);
                end
                @(negedge clk);
            end
            readDataValid = 1'b0;
        end else begin
            feed_words(rnd);
        end
        finish_done(ok, hold);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #1;
        checks++;
        if ({testParamsStop, readParamsValid, testDoneValid, readDataStop, readDoneStop} !== 5'b10011) begin
            errors++;
            $display("FAIL reset_outputs: pstop/rpv/tdv/rds/rdns=%b required 10011",
                     {testParamsStop, readParamsValid, testDoneValid, readDataStop, readDoneStop});
        end
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        #1;
        checks++;
        if (testParamsStop !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: testParamsStop=%b required 0", testParamsStop);
        end
    endtask

    task automatic test_clean();
        run_test(64'h0000_1000_0000_0040, 32'd4, 8'h5a, 64'h10, 64'd1, -1, -1, 1'b1, 0, 0);
    endtask

    task automatic test_errors();
        run_test(64'h2000, 32'd8, 8'h01, 64'd0, 64'd8, 2, 5, 1'b1, 0, 0);
    endtask

    task automatic test_wrap();
        run_test(64'h3000, 32'd3, 8'h02, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, -1, -1, 1'b1, 0, 0);
    endtask

    task automatic test_status_fail();
        run_test(64'h3800, 32'd2, 8'h03, 64'h77, 64'h3, -1, -1, 1'b0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_test(64'h4000, 32'd12, 8'hc3, 64'h1234_5678_9abc_def0, 64'h1111, -1, -1, 1'b1, 1, 5);
        run_test(64'h4800, 32'd9, 8'h3c, 64'h99, 64'h7, 0, 8, 1'b1, 1, 2);
    endtask

    task automatic test_len_zero();
        run_test(64'h5000, 32'd0, 8'h44, 64'hab, 64'd1, -1, -1, 1'b1, 0, 0);
        run_test(64'h5800, 32'd0, 8'h45, 64'hab, 64'd1, -1, -1, 1'b0, 0, 1);
    endtask

    task automatic test_back_to_back();
        run_test(64'h6000, 32'd1, 8'h10, 64'h5, 64'd2, -1, -1, 1'b1, 0, 0);
        run_test(64'h6100, 32'd1, 8'h11, 64'h9, 64'd2, 0, -1, 1'b1, 0, 0);
    endtask

    task automatic test_reset_mid();
        send_cmd(64'h7000, 32'd6, 8'h77, 64'h100, 64'd1);
        accept_req(0);
        for (int i = 0; i < 2; i++) begin
            readDataValid = 1'b1;
            readDataValue = 64'h0;
            @(negedge clk);
        end
        readDataValid = 1'b0;
        arst_n = 1'b0;
        #1;
        checks++;
        if ({testParamsStop, readParamsValid, testDoneValid, readDataStop, readDoneStop} !== 5'b10011) begin
            errors++;
            $display("FAIL midreset_outputs: pstop/rpv/tdv/rds/rdns=%b required 10011",
                     {testParamsStop, readParamsValid, testDoneValid, readDataStop, readDoneStop});
        end
        @(negedge clk);
        arst_n = 1'b1;
        run_test(64'h7800, 32'd5, 8'h78, 64'h200, 64'd3, -1, -1, 1'b1, 0, 0);
    endtask

    initial begin
        testParamsValid    = 1'b0;
        testParamBurstAddr = '0;
        testParamBurstLen  = '0;
        testParamBurstOpts = '0;
        testParamDataInit  = '0;
        testParamDataIncr  = '0;
        testDoneStop       = 1'b0;
        readParamsStop     = 1'b0;
        readDataValid      = 1'b0;
        readDataValue      = '0;
        readDoneValid      = 1'b0;
        readDoneStatusOk   = 1'b0;
        arst_n             = 1'b1;
        @(negedge clk);
        test_reset();
        test_clean();
        test_errors();
        test_wrap();
        test_status_fail();
        test_backpressure();
        test_len_zero();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (res_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending results=%0d requests=%0d required 0 0",
                     res_q.size(), req_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
